// File: rtl/subservient_rf_pkg.sv
// -----------------------------------------------------------------------------
// subservient_rf_pkg
//   Shared definitions for the SERV register-file serialiser/deserialiser:
//   FSM state encodings, the bit-slot positions used to prefetch the next
//   read byte, and the mapping from (register index, byte) to SRAM address.
// -----------------------------------------------------------------------------
package subservient_rf_pkg;

    // Bit slots inside each 8-bit group of the read stream (slot = bit index
    // modulo 8). The rs2 address is on o_raddr during RD_SLOT_RS2, the rs1
    // address during RD_SLOT_RS1, and both shift registers reload at the end
    // of LOAD_SLOT. LOAD_SLOT is also the slot in which a write byte completes.
    localparam logic [2:0] RD_SLOT_RS2 = 3'd5;
    localparam logic [2:0] RD_SLOT_RS1 = 3'd6;
    localparam logic [2:0] LOAD_SLOT   = 3'd7;

    // Widest address / register index the mapping helper handles; callers
    // truncate the result to their own address width.
    localparam int ADDR_MAX = 32;
    localparam int REG_MAX  = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_PRE,
        RD_SHIFT
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SHIFT,
        WR_FLUSH
    } wr_state_t;

    // Register r, byte k lives at {all-ones, ~r, k}. Zero-extending r and then
    // inverting it yields the all-ones prefix above the index for free, so the
    // same expression works for any register width up to REG_MAX.
    function automatic logic [ADDR_MAX-1:0] rf_addr(input logic [REG_MAX-1:0] r,
                                                    input logic [1:0]         k);
        return {~{{(ADDR_MAX-2-REG_MAX){1'b0}}, r}, k};
    endfunction

endpackage

// File: rtl/subservient_rf_serdes_if.sv
// -----------------------------------------------------------------------------
// subservient_rf_serdes_if
//   Byte-wide register-file port between the serdes (master) and the
//   downstream RF/data SRAM mux (slave).
//     waddr  aw  SRAM byte write address
//     wdata  8   SRAM write byte
//     wen    1   SRAM write strobe
//     raddr  aw  SRAM byte read address
//     rdata  8   SRAM read byte, valid one cycle after raddr
// -----------------------------------------------------------------------------
interface subservient_rf_serdes_if #(
    parameter int aw = 8
);
    logic [aw-1:0] waddr;
    logic [7:0]    wdata;
    logic          wen;
    logic [aw-1:0] raddr;
    logic [7:0]    rdata;

    modport master (
        output waddr,
        output wdata,
        output wen,
        output raddr,
        input  rdata
    );

    modport slave (
        input  waddr,
        input  wdata,
        input  wen,
        input  raddr,
        output rdata
    );
endinterface

// File: rtl/subservient_rf_wr_deser.sv
// -----------------------------------------------------------------------------
// subservient_rf_wr_deser
//   Write half of the register-file serdes. Collects two LSB-first serial
//   write streams, one byte at a time, and emits each completed byte to the
//   SRAM: port 0 byte k in cycle W9+8k, port 1 byte k in cycle W10+8k, where
//   W0 is the cycle carrying i_wreq.
//   Ports:
//     i_clk, i_rst          clock, synchronous active-high reset
//     i_wreq                op start pulse (ignored unless idle)
//     i_wreg0/1, i_wen0/1   register index and enable per port, sampled at i_wreq
//     i_wdata0/1            serial write data, bit i in cycle W1+i
//     waddr, wdata, wen     registered SRAM write port
// -----------------------------------------------------------------------------
module subservient_rf_wr_deser
    import subservient_rf_pkg::*;
#(
    parameter int aw = 8,
    parameter int rw = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wreq,
    input  logic [rw-1:0] i_wreg0,
    input  logic [rw-1:0] i_wreg1,
    input  logic          i_wen0,
    input  logic          i_wen1,
    input  logic          i_wdata0,
    input  logic          i_wdata1,
    output logic [aw-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          wen
);

    function automatic logic [aw-1:0] addr_of(input logic [rw-1:0] r, input logic [1:0] k);
        return aw'(rf_addr({{(REG_MAX-rw){1'b0}}, r}, k));
    endfunction

    wr_state_t     state;
    logic [4:0]    cnt;
    logic [rw-1:0] wreg0;
    logic [rw-1:0] wreg1;
    logic          en0;
    logic          en1;
    logic [6:0]    sr0;       // bits already received of the current byte
    logic [6:0]    sr1;
    logic [7:0]    wbuf1;     // port 1 byte waiting one cycle behind port 0
    logic          pend1;
    logic [1:0]    pend_byte;

    // NOTE: every register here is updated with <= so all of them see the
    // values from before the clock edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= WR_IDLE;
            cnt       <= '0;
            wreg0     <= '0;
            wreg1     <= '0;
            en0       <= 1'b0;
            en1       <= 1'b0;
            sr0       <= '0;
            sr1       <= '0;
            wbuf1     <= '0;
            pend1     <= 1'b0;
            pend_byte <= '0;
            waddr     <= '0;
            wdata     <= '0;
            wen       <= 1'b0;
        end else begin
            wen <= 1'b0;

            case (state)
                WR_IDLE: begin
                    if (i_wreq) begin
                        wreg0 <= i_wreg0;
                        wreg1 <= i_wreg1;
                        // Register 0 is hard-wired to zero, so writes to it are dropped.
                        en0   <= i_wen0 & (i_wreg0 != '0);
                        en1   <= i_wen1 & (i_wreg1 != '0);
                        cnt   <= '0;
                        state <= WR_SHIFT;
                    end
                end

                WR_SHIFT: begin
                    cnt <= cnt + 5'd1;
                    sr0 <= {i_wdata0, sr0[6:1]};
                    sr1 <= {i_wdata1, sr1[6:1]};
                    if (cnt[2:0] == LOAD_SLOT) begin
                        // The port 0 byte goes straight to the SRAM port; the
                        // port 1 byte is buffered and follows one cycle later.
                        wen       <= en0;
                        waddr     <= addr_of(wreg0, cnt[4:3]);
                        wdata     <= {i_wdata0, sr0};
                        wbuf1     <= {i_wdata1, sr1};
                        pend1     <= 1'b1;
                        pend_byte <= cnt[4:3];
                    end
                    if (cnt == 5'd31) begin
                        state <= WR_FLUSH;
                    end
                end

                WR_FLUSH: begin
                    // Two cycles: the last port 1 byte goes out, then the
                    // strobe drops before a new op may start.
                    cnt <= cnt + 5'd1;
                    if (cnt[0]) begin
                        state <= WR_IDLE;
                    end
                end

                default: state <= WR_IDLE;
            endcase

            if (pend1) begin
                pend1 <= 1'b0;
                wen   <= en1;
                waddr <= addr_of(wreg1, pend_byte);
                wdata <= wbuf1;
            end
        end
    end

endmodule

// File: rtl/subservient_rf_serdes.sv
// -----------------------------------------------------------------------------
// subservient_rf_serdes
//   Converts SERV's bit-serial dual-read/dual-write register-file protocol to
//   the byte-wide RF port of the shared SRAM mux. Registers sit at the top of
//   the SRAM: register r, byte k at {all-ones, ~r, k}.
//   Ports:
//     i_clk, i_rst            clock, synchronous active-high reset
//     i_wreq, i_wreg0/1,
//     i_wen0/1, i_wdata0/1    serial write side (see subservient_rf_wr_deser)
//     i_rreq                  read op start pulse (ignored unless idle)
//     i_rreg0/1               rs1 / rs2 register index, sampled at i_rreq
//     o_ready                 pulse in R3; read bit 0 follows in R4
//     o_rdata0/1              serial rs1 / rs2 data, bit i in cycle R4+i
//     rf                      byte-wide SRAM port (master side)
// -----------------------------------------------------------------------------
module subservient_rf_serdes
    import subservient_rf_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth),
    parameter int rw    = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wreq,
    input  logic          i_rreq,
    input  logic [rw-1:0] i_wreg0,
    input  logic [rw-1:0] i_wreg1,
    input  logic          i_wen0,
    input  logic          i_wen1,
    input  logic          i_wdata0,
    input  logic          i_wdata1,
    input  logic [rw-1:0] i_rreg0,
    input  logic [rw-1:0] i_rreg1,
    output logic          o_ready,
    output logic          o_rdata0,
    output logic          o_rdata1,
    subservient_rf_serdes_if.master rf
);

    function automatic logic [aw-1:0] addr_of(input logic [rw-1:0] r, input logic [1:0] k);
        return aw'(rf_addr({{(REG_MAX-rw){1'b0}}, r}, k));
    endfunction

    // ------------------------------------------------------------------ write
    logic [aw-1:0] wr_waddr;
    logic [7:0]    wr_wdata;
    logic          wr_wen;

    subservient_rf_wr_deser #(
        .aw (aw),
        .rw (rw)
    ) u_wr_deser (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wreq   (i_wreq),
        .i_wreg0  (i_wreg0),
        .i_wreg1  (i_wreg1),
        .i_wen0   (i_wen0),
        .i_wen1   (i_wen1),
        .i_wdata0 (i_wdata0),
        .i_wdata1 (i_wdata1),
        .waddr    (wr_waddr),
        .wdata    (wr_wdata),
        .wen      (wr_wen)
    );

    assign rf.waddr = wr_waddr;
    assign rf.wdata = wr_wdata;
    assign rf.wen   = wr_wen;

    // ------------------------------------------------------------------- read
    rd_state_t     rd_state;
    logic [4:0]    rd_cnt;     // PRE: phase 0..2, SHIFT: bit index 0..31
    logic [rw-1:0] rs1;
    logic [rw-1:0] rs2;
    logic [7:0]    hold1;      // rs2 byte parked while rs1 is being fetched
    logic [7:0]    sh0;
    logic [7:0]    sh1;
    logic [aw-1:0] raddr;
    logic          ready;
    logic [1:0]    next_byte;
    logic          more_bytes;

    assign next_byte  = rd_cnt[4:3] + 2'd1;
    assign more_bytes = (rd_cnt[4:3] != 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_state <= RD_IDLE;
            rd_cnt   <= '0;
            rs1      <= '0;
            rs2      <= '0;
            hold1    <= '0;
            sh0      <= '0;
            sh1      <= '0;
            raddr    <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= 1'b0;

            case (rd_state)
                RD_IDLE: begin
                    if (i_rreq) begin
                        rs1      <= i_rreg0;
                        rs2      <= i_rreg1;
                        raddr    <= addr_of(i_rreg1, 2'd0);
                        rd_cnt   <= '0;
                        rd_state <= RD_PRE;
                    end
                end

                // Byte 0 is fetched before the stream starts: rs2 address in
                // R1, rs1 address in R2, both bytes loaded at the end of R3.
                RD_PRE: begin
                    rd_cnt <= rd_cnt + 5'd1;
                    case (rd_cnt[1:0])
                        2'd0: raddr <= addr_of(rs1, 2'd0);
                        2'd1: begin
                            hold1 <= rf.rdata;
                            ready <= 1'b1;
                        end
                        default: begin
                            sh0      <= rf.rdata;
                            sh1      <= hold1;
                            rd_cnt   <= '0;
                            rd_state <= RD_SHIFT;
                        end
                    endcase
                end

                // Bytes 1..3 are prefetched with the same three-cycle pattern,
                // timed so the reload lands exactly as the last bit leaves.
                RD_SHIFT: begin
                    rd_cnt <= rd_cnt + 5'd1;
                    if (more_bytes && rd_cnt[2:0] == LOAD_SLOT) begin
                        sh0 <= rf.rdata;
                        sh1 <= hold1;
                    end else begin
                        sh0 <= {1'b0, sh0[7:1]};
                        sh1 <= {1'b0, sh1[7:1]};
                    end
                    if (more_bytes) begin
                        if (rd_cnt[2:0] == RD_SLOT_RS2 - 3'd1) begin
                            raddr <= addr_of(rs2, next_byte);
                        end
                        if (rd_cnt[2:0] == RD_SLOT_RS1 - 3'd1) begin
                            raddr <= addr_of(rs1, next_byte);
                        end
                        if (rd_cnt[2:0] == RD_SLOT_RS1) begin
                            hold1 <= rf.rdata;
                        end
                    end
                    if (rd_cnt == 5'd31) begin
                        rd_state <= RD_IDLE;
                    end
                end

                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign rf.raddr = raddr;
    assign o_ready  = ready;
    // Serial outputs are forced low outside the bit stream.
    assign o_rdata0 = (rd_state == RD_SHIFT) & sh0[0];
    assign o_rdata1 = (rd_state == RD_SHIFT) & sh1[0];

endmodule

// File: doc/subservient_rf_serdes.md
Name: subservient_rf_serdes

Overview:
Upstream neighbour of the shared RF/data SRAM mux. It converts the bit-serial dual-read/dual-write register-file protocol of the SERV core into the byte-wide RF port of that mux: i_waddr/i_wdata/i_wen/i_raddr/o_rdata. GPRs and CSRs are mapped into the top of the SRAM, with register index r at word {all-ones prefix, ~r}. Register 0 therefore maps to the all-ones word, which the downstream mux forces to read as zero.

Parameters:
depth, 256, SRAM depth in bytes.
aw, $clog2(depth), byte address width; must satisfy aw >= rw+2.
rw, 6, register index width (32 GPR + CSR words).

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_wreq  in  1  write-op start pulse; samples i_wreg*/i_wen*
i_rreq  in  1  read-op start pulse; samples i_rreg*
i_wreg0  in  rw  write port 0 register index
i_wreg1  in  rw  write port 1 register index
i_wen0  in  1  write port 0 enable for this op
i_wen1  in  1  write port 1 enable for this op
i_wdata0  in  1  serial write data port 0, LSB first
i_wdata1  in  1  serial write data port 1, LSB first
i_rreg0  in  rw  read port 0 (rs1) register index
i_rreg1  in  rw  read port 1 (rs2) register index
o_ready  out  1  one-cycle pulse; read bit 0 appears on the next cycle
o_rdata0  out  1  serial read data rs1, LSB first
o_rdata1  out  1  serial read data rs2, LSB first
o_waddr  out  aw  SRAM byte write address (registered)
o_wdata  out  8  SRAM write byte (registered)
o_wen  out  1  SRAM write strobe (registered)
o_raddr  out  aw  SRAM byte read address (registered)
i_rdata  in  8  SRAM read byte; valid one cycle after o_raddr

Behaviour:
- Address of reg r, byte k: {{(aw-2-rw){1'b1}}, ~r, k[1:0]}.
- Reset: all outputs 0; read FSM and write FSM return to IDLE; any in-flight op is abandoned with no further o_wen.
- Read FSM (IDLE, PRE, SHIFT):
  - Cycle R0 has i_rreq=1. Latch rreg0/rreg1, go to PRE.
  - o_raddr holds rs2 byte0 in R1 and rs1 byte0 in R2.
  - R2: i_rdata is stored into hold1.
  - R3: sh0<=i_rdata, sh1<=hold1, o_ready=1.
  - Bit i is driven in cycle R4+i (SHIFT, 5-bit counter). Shift registers shift right.
  - Byte k+1 prefetch (k<3): rs2 address at bit slot 8k+5, rs1 address at slot 8k+6. hold1 captures at 8k+6; sh0/sh1 load at end of 8k+7.
  - After bit 31, return to IDLE. o_rdata0/1 are 0 when idle.
  - i_rreq while not IDLE is ignored.
- Write FSM (IDLE, SHIFT, FLUSH):
  - Cycle W0 has i_wreq=1. Latch wreg*/wen*. Effective enable is wenN & (wregN!=0).
  - Bit i is sampled in cycle W1+i.
  - When a byte completes (bit 8k+7), copy the full byte into wbuf0/wbuf1.
  - o_wen/o_waddr/o_wdata present port0 byte k in cycle W9+8k and port1 byte k in W10+8k. o_wen is 0 for a disabled port.
  - FLUSH covers W33..W34; IDLE from W35.
  - i_wreq while not IDLE is ignored.
- Read and write FSMs are independent and may overlap. There is no read-after-write forwarding: a concurrent read of a register being written returns byte-wise old or new data.
- SRAM arbitration against Wishbone is the downstream block's responsibility.

Decomposition:
- Package subservient_rf_pkg holds: byte-slot constants (RD_SLOT_RS2=5, RD_SLOT_RS1=6, LOAD_SLOT=7) and the address-mapping function rf_addr(r,k).
- One natural sub-module, subservient_rf_wr_deser, implements the write FSM and byte buffers. The read path stays in the top module.

Test Plan:
- Reset mid-write (i_rst at W12) -> o_wen never asserts afterwards; all outputs 0 next cycle.
- Write reg 5 = 0xA5C3_0F81 on port0 (wen1=0) -> o_wen at W9/W17/W25/W33 only. Bytes are 0x81, 0x0F, 0xC3, 0xA5 at addr {1..1,~5,k}.
- Dual write reg3=0x12345678, reg7=0xDEADBEEF -> alternating o_wen on consecutive cycles. W9 writes 0x78 to reg3 byte0; W10 writes 0xEF to reg7 byte0; all 8 bytes are correct.
- Write to reg0 with wen0=1 -> no o_wen for port0 over the whole op.
- Read rs1=reg5, rs2=reg7 after the writes above -> o_ready at R3. o_rdata0 serialises 0xA5C30F81 and o_rdata1 serialises 0xDEADBEEF over R4..R35. o_raddr sequence matches the prefetch slots.
- Read and write overlapping (i_rreq at W4 for reg9) -> the read stream of reg9 is intact and the write bytes are unaffected.
